// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - handshaked memory stage between execute and writeback
//
// Purpose:
//   Passes non-memory results through one output register. Aligned loads and
//   stores issue a single data-memory request and wait for its response.
//   Misaligned accesses are trapped locally and reported on out_misalign.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_*                     upstream instruction (valid/ready handshake)
//   mem_req_*                data-memory request (valid/ready handshake)
//   mem_rsp_valid/rdata      memory response or store acknowledge
//   out_*                    writeback result (valid/ready handshake)
module mem_stage_pipe #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mem_rd,
    input  logic                in_mem_wr,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [XLEN-1:0]     in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [XLEN-1:0]     in_alu_data,
    input  logic [REG_AW-1:0]   in_w_addr,
    input  logic                in_reg_wr,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [XLEN-1:0]     mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic [REG_AW-1:0]   out_w_addr,
    output logic                out_reg_wr,
    output logic                out_misalign
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state_q, state_d;

    // Operands latched at accept of a memory instruction
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [REG_AW-1:0] w_addr_q;
    logic              reg_wr_q;

    // Output register
    logic              out_valid_q;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [REG_AW-1:0] out_w_addr_q, out_w_addr_d;
    logic              out_reg_wr_q, out_reg_wr_d;
    logic              out_mis_q, out_mis_d;
    logic              load_out;

    logic              accept;
    logic              is_mem;
    logic              misalign;

    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   rsp_shifted;
    logic [7:0]        ext_sh;
    logic [XLEN-1:0]   ld_left;
    logic signed [XLEN-1:0] ld_sra;
    logic [XLEN-1:0]   ld_data;
    logic [7:0]        size_mask;
    logic [STRB_W-1:0] lane_mask;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign in_ready = rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_mem_rd || in_mem_wr;

    always_comb begin
        misalign = 1'b0;
        case (in_size)
            2'd1:    misalign = in_addr[0];
            2'd2:    misalign = |in_addr[1:0];
            2'd3:    misalign = (XLEN == 32) || (|in_addr[2:0]);
            default: misalign = 1'b0;
        endcase
    end

    assign off_q = addr_q[OFF_W-1:0];

    // Load: move the addressed lane to bit 0, push it to the top, then shift
    // back down logically or arithmetically to zero- or sign-extend.
    assign rsp_shifted = mem_rsp_rdata >> {off_q, 3'b000};

    always_comb begin
        ext_sh = 8'd0;
        case (size_q)
            2'd0:    ext_sh = 8'(XLEN - 8);
            2'd1:    ext_sh = 8'(XLEN - 16);
            2'd2:    ext_sh = 8'(XLEN - 32);
            default: ext_sh = 8'd0;
        endcase
    end

    assign ld_left = rsp_shifted << ext_sh;
    assign ld_sra  = $signed(ld_left) >>> ext_sh;
    assign ld_data = uns_q ? (ld_left >> ext_sh) : $unsigned(ld_sra);

    always_comb begin
        size_mask = 8'hFF;
        case (size_q)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign lane_mask     = STRB_W'(size_mask);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_wdata = wdata_q << {off_q, 3'b000};
    assign mem_req_wmask = we_q ? (lane_mask << off_q) : {STRB_W{1'b1}};

    always_comb begin
        state_d      = state_q;
        load_out     = 1'b0;
        out_data_d   = '0;
        out_w_addr_d = w_addr_q;
        out_reg_wr_d = 1'b0;
        out_mis_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mem && !misalign) begin
                        state_d = S_REQ;
                    end else begin
                        load_out     = 1'b1;
                        out_w_addr_d = in_w_addr;
                        if (is_mem) begin
                            out_mis_d  = 1'b1;
                            out_data_d = in_addr;
                        end else begin
                            out_data_d   = in_alu_data;
                            out_reg_wr_d = in_reg_wr && (|in_w_addr);
                        end
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The output register is free here: accept required it to be
                // empty or draining, and nothing else loads it meanwhile.
                if (mem_rsp_valid) begin
                    state_d  = S_IDLE;
                    load_out = 1'b1;
                    if (!we_q) begin
                        out_data_d   = ld_data;
                        out_reg_wr_d = reg_wr_q && (|w_addr_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            w_addr_q <= '0;
            reg_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && is_mem) begin
                we_q     <= in_mem_wr;
                size_q   <= in_size;
                uns_q    <= in_unsigned;
                addr_q   <= in_addr;
                wdata_q  <= in_wdata;
                w_addr_q <= in_w_addr;
                reg_wr_q <= in_reg_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_w_addr_q <= '0;
            out_reg_wr_q <= 1'b0;
            out_mis_q    <= 1'b0;
        end else if (load_out) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= out_data_d;
            out_w_addr_q <= out_w_addr_d;
            out_reg_wr_q <= out_reg_wr_d;
            out_mis_q    <= out_mis_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_w_addr   = out_w_addr_q;
    assign out_reg_wr   = out_reg_wr_q;
    assign out_misalign = out_mis_q;

endmodule
